// File: rtl/lcd_frame_ctrl_if.sv
// Host-side bus of the LCD frame controller: character-buffer writes, refresh
// request, status flags and the HD44780 pins.
interface lcd_frame_ctrl_if;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              refresh_req;
    logic              init_done;
    logic              frame_done;
    logic              lcd_rs;
    logic              lcd_rw;
    logic              lcd_en;
    logic [DATA_W-1:0] lcd_data;

    modport master (
        output wr_en, wr_addr, wr_data, refresh_req,
        input  init_done, frame_done, lcd_rs, lcd_rw, lcd_en, lcd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, refresh_req,
        output init_done, frame_done, lcd_rs, lcd_rw, lcd_en, lcd_data
    );
endinterface

// File: rtl/lcd_frame_ctrl.sv
// HD44780 character-LCD driver: power-up wait, init commands, then frames
// streamed from an internal character buffer, one byte per timed step.
module lcd_frame_ctrl #(
    parameter int unsigned STEP_CYC     = 270000,
    parameter int unsigned EN_RISE      = 67499,
    parameter int unsigned EN_FALL      = 202499,
    parameter int unsigned PWRUP_STEPS  = 20,
    parameter int unsigned ROWS         = 2,
    parameter int unsigned COLS         = 16,
    parameter bit          AUTO_REFRESH = 1'b1,
    parameter logic [7:0]  SUB_CHAR     = 8'h3F
) (
    input logic             clk,
    input logic             reset,
    lcd_frame_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam int unsigned PW_W  = $clog2(PWRUP_STEPS + 1);
    localparam int unsigned NCELL = ROWS * COLS;
    localparam int unsigned IDX_W = (NCELL > 1) ? $clog2(NCELL) : 1;
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ADR_W = 7;

    typedef enum logic [2:0] {
        S_PWRUP, S_FUNC, S_CLEAR, S_DISP, S_ENTRY, S_ROW, S_CHAR, S_IDLE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW_W-1:0]  pwr_q, pwr_d;
    logic             row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             dirty_q, dirty_d;
    logic             pend_q, pend_d;
    logic             init_done_q, init_done_d;
    logic             frame_done_q, frame_done_d;
    logic             lcd_en_q, lcd_en_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic [7:0]       lcd_data_q, lcd_data_d;
    logic [7:0]       buf_q [NCELL];

    logic             tick_c;
    logic             frame_start_c;
    logic             wr_ok_c;
    logic [IDX_W-1:0] wr_idx_c;
    logic [7:0]       cell_c;

    assign tick_c   = (cnt_q == CNT_W'(STEP_CYC - 1));
    assign wr_ok_c  = bus.wr_en && (bus.wr_addr < ADR_W'(NCELL));
    assign wr_idx_c = IDX_W'(bus.wr_addr);
    assign cell_c   = buf_q[ptr_q];

    // Sequencer: everything except the step counter moves only on a tick.
    always_comb begin
        cnt_d         = tick_c ? '0 : cnt_q + CNT_W'(1);
        state_d       = state_q;
        pwr_d         = pwr_q;
        row_d         = row_q;
        col_d         = col_q;
        ptr_d         = ptr_q;
        init_done_d   = init_done_q;
        frame_done_d  = 1'b0;
        lcd_rs_d      = lcd_rs_q;
        lcd_data_d    = lcd_data_q;
        frame_start_c = 1'b0;

        if (tick_c) begin
            case (state_q)
                S_PWRUP: begin
                    if (pwr_q == PW_W'(PWRUP_STEPS - 1)) state_d = S_FUNC;
                    else                                  pwr_d   = pwr_q + PW_W'(1);
                end
                S_FUNC:  state_d = S_CLEAR;
                S_CLEAR: state_d = S_DISP;
                S_DISP:  state_d = S_ENTRY;
                S_ENTRY: begin
                    init_done_d   = 1'b1;
                    frame_start_c = 1'b1;
                end
                S_ROW: begin
                    state_d = S_CHAR;
                    col_d   = '0;
                end
                S_CHAR: begin
                    if (col_q != COL_W'(COLS - 1)) begin
                        col_d = col_q + COL_W'(1);
                    end else if (row_q != 1'(ROWS - 1)) begin
                        state_d = S_ROW;
                        row_d   = 1'b1;
                    end else begin
                        frame_done_d = 1'b1;
                        if (AUTO_REFRESH) frame_start_c = 1'b1;
                        else              state_d       = S_IDLE;
                    end
                end
                S_IDLE:  if (dirty_q || pend_q) frame_start_c = 1'b1;
                default: state_d = S_PWRUP;
            endcase

            if (frame_start_c) begin
                state_d = S_ROW;
                row_d   = 1'b0;
                ptr_d   = '0;
            end

            // Byte presented for the step being entered; held until the next tick.
            case (state_d)
                S_FUNC:  begin lcd_rs_d = 1'b0; lcd_data_d = (ROWS == 2) ? 8'h38 : 8'h30; end
                S_CLEAR: begin lcd_rs_d = 1'b0; lcd_data_d = 8'h01; end
                S_DISP:  begin lcd_rs_d = 1'b0; lcd_data_d = 8'h0C; end
                S_ENTRY: begin lcd_rs_d = 1'b0; lcd_data_d = 8'h06; end
                S_ROW:   begin lcd_rs_d = 1'b0; lcd_data_d = row_d ? 8'hC0 : 8'h80; end
                S_CHAR: begin
                    lcd_rs_d   = 1'b1;
                    lcd_data_d = cell_c[7] ? SUB_CHAR : cell_c;
                    ptr_d      = ptr_q + IDX_W'(1);
                end
                default: ;
            endcase
        end

        lcd_en_d = (cnt_d >= CNT_W'(EN_RISE)) && (cnt_d <= CNT_W'(EN_FALL)) &&
                   (state_d != S_PWRUP) && (state_d != S_IDLE);

        // A write or request in the same cycle as the clearing tick survives it.
        dirty_d = (tick_c && frame_start_c) ? 1'b0 : dirty_q;
        if (wr_ok_c) dirty_d = 1'b1;
        pend_d  = (tick_c && frame_start_c) ? 1'b0 : pend_q;
        if (bus.refresh_req) pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_PWRUP;
            cnt_q        <= '0;
            pwr_q        <= '0;
            row_q        <= 1'b0;
            col_q        <= '0;
            ptr_q        <= '0;
            dirty_q      <= 1'b0;
            pend_q       <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            lcd_en_q     <= 1'b0;
            lcd_rs_q     <= 1'b0;
            lcd_data_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pwr_q        <= pwr_d;
            row_q        <= row_d;
            col_q        <= col_d;
            ptr_q        <= ptr_d;
            dirty_q      <= dirty_d;
            pend_q       <= pend_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
            lcd_en_q     <= lcd_en_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_data_q   <= lcd_data_d;
        end
    end

    // Character buffer, cleared to spaces.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NCELL); i++) buf_q[i] <= 8'h20;
        end else if (wr_ok_c) begin
            buf_q[wr_idx_c] <= bus.wr_data;
        end
    end

    assign bus.init_done  = init_done_q;
    assign bus.frame_done = frame_done_q;
    assign bus.lcd_en     = lcd_en_q;
    assign bus.lcd_rs     = lcd_rs_q;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_data   = lcd_data_q;

endmodule

// File: doc/lcd_frame_ctrl.md
LCD_FRAME_CTRL -- requirements
Module: lcd_frame_ctrl

Interface
REQ-001 The block SHALL have parameter STEP_CYC, default 270000; clock cycles per LCD step (5 ms at 54 MHz).
REQ-002 The block SHALL have parameter EN_RISE, default 67499; step-counter value at which lcd_en rises.
REQ-003 The block SHALL have parameter EN_FALL, default 202499; last step-counter value with lcd_en high.
REQ-004 The block SHALL have parameter PWRUP_STEPS, default 20; power-up wait, in steps.
REQ-005 The block SHALL have parameter ROWS, default 2; display rows, legal values 1 or 2.
REQ-006 The block SHALL have parameter COLS, default 16; characters per row, legal range 1..40.
REQ-007 The block SHALL have parameter AUTO_REFRESH, default 1; 1 = continuous refresh, 0 = refresh on demand.
REQ-008 The block SHALL have parameter SUB_CHAR, default 8'h3F; code sent in place of any buffer byte >= 8'h80.
REQ-009 The block SHALL have port clk, input, 1 bit; the single clock.
REQ-010 The block SHALL have port reset, input, 1 bit; asynchronous, active-low reset.
REQ-011 The block SHALL have port wr_en, input, 1 bit; character-buffer write strobe.
REQ-012 The block SHALL have port wr_addr, input, 7 bits; cell index row*COLS+col.
REQ-013 The block SHALL have port wr_data, input, 8 bits; character code.
REQ-014 The block SHALL have port refresh_req, input, 1 bit; one-cycle frame request, used when AUTO_REFRESH=0.
REQ-015 The block SHALL have port init_done, output, 1 bit; high once the init sequence has completed.
REQ-016 The block SHALL have port frame_done, output, 1 bit; one-cycle pulse when a frame completes.
REQ-017 The block SHALL have ports lcd_rs (output, 1 bit), lcd_rw (output, 1 bit) and lcd_en (output, 1 bit); HD44780 control lines.
REQ-018 The block SHALL have port lcd_data, output, 8 bits; HD44780 data bus.

Function
REQ-019 The step counter SHALL run 0..STEP_CYC-1 and wrap; a step tick SHALL occur when it equals STEP_CYC-1.
REQ-020 The state SHALL change only on a step tick.
- State sequence: PWRUP(PWRUP_STEPS ticks) -> FUNC_SET -> CLEAR -> DISP_ON -> ENTRY -> ROW_ADDR -> CHAR ... -> ROW_ADDR -> CHAR ... -> (ROW_ADDR or IDLE).
REQ-021 The command byte SHALL be 0x38 (ROWS=2) or 0x30 (ROWS=1) in FUNC_SET, 0x01 in CLEAR, 0x0C in DISP_ON and 0x06 in ENTRY, with lcd_rs=0 in each of these states.
REQ-022 ROW_ADDR SHALL send lcd_rs=0 with lcd_data 0x80 for row 0 and 0xC0 for row 1.
- Each ROW_ADDR is followed by exactly COLS CHAR steps for that row.
REQ-023 Each CHAR step SHALL send lcd_rs=1 and the buffer byte for that cell, or SUB_CHAR if the byte is >= 0x80.
REQ-024 The buffer byte SHALL be sampled on the tick that enters the CHAR step and held for the whole step.
REQ-025 lcd_en SHALL be 1 only while the step counter is in [EN_RISE, EN_FALL] and the state is neither PWRUP nor IDLE.
REQ-026 lcd_rw SHALL be constant 0.
REQ-027 lcd_rs, lcd_data and lcd_en SHALL be registered outputs.
REQ-028 init_done SHALL rise on the tick that enters the first ROW_ADDR and SHALL stay high until reset.
REQ-029 frame_done SHALL pulse for one cycle on the tick that ends the last CHAR of the last row.
REQ-030 A write with wr_en=1 and wr_addr < ROWS*COLS SHALL update the cell on the next clk edge; all other writes SHALL be ignored.
- Writes are accepted in any state, including during PWRUP.
REQ-031 Any accepted write SHALL set a dirty flag; the tick that enters ROW_ADDR for row 0 SHALL clear it.
- A write in the same cycle as that tick leaves dirty set.
REQ-032 With AUTO_REFRESH=1, the end of a frame SHALL go to ROW_ADDR for row 0; IDLE SHALL be unused.
REQ-033 With AUTO_REFRESH=0, the end of a frame SHALL go to IDLE.
REQ-034 From IDLE, the first tick with dirty=1, or with refresh_req seen since the last frame, SHALL enter ROW_ADDR for row 0.
- The latched refresh request clears on that tick.
REQ-035 A write to a cell currently being displayed SHALL NOT alter that step's lcd_data.

Reset
REQ-036 While reset=0, all of the following SHALL hold immediately (asynchronously):
- state = PWRUP; step counter = 0; power-up count = 0.
- lcd_en = 0, lcd_rs = 0, lcd_data = 0x00.
- init_done = 0, frame_done = 0, dirty = 0, pending refresh = 0.
- every buffer cell = 0x20.
REQ-037 A reset asserted mid-operation SHALL abort any step in progress and restart the full init sequence after release.

Verification
(All scenarios use STEP_CYC=10, EN_RISE=2, EN_FALL=6, PWRUP_STEPS=3, ROWS=2, COLS=4.)
REQ-038 Init: release reset -> lcd_en=0 for the first 30 cycles; then commands 0x38, 0x01, 0x0C, 0x06 each hold for 10 cycles with lcd_en high for 5 cycles; init_done rises at cycle 70.
REQ-039 Frame content: write "ABCD" to cells 0-3 and 0x41 to cell 7 during PWRUP -> one frame shows 0x80, A, B, C, D, 0xC0, 0x20, 0x20, 0x20, 0x41; frame_done pulses once, 100 cycles after init_done.
REQ-040 Substitution and range: write 0x9A to cell 2 and 0x55 to addr 8 -> cell 2 displays 0x3F; addr 8 is ignored, with no change to the frame and dirty not set.
REQ-041 On-demand mode (AUTO_REFRESH=0): after the first frame -> IDLE with lcd_en=0. A refresh_req pulse -> exactly one more frame. A write mid-frame -> a second frame follows without any request.
REQ-042 Reset mid-CHAR while lcd_en=1 -> lcd_en falls within the same cycle; after release the full init replays and the buffer reads all 0x20.
